sweep_controller: RTL and testbench
===================================

SWEEP_CONTROLLER -- requirements
Module: sweep_controller

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the width of the controlled counter value.
REQ-002 The block SHALL have parameter C, default 8, giving the width of the sweep-count limit.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: single-cycle request to begin a sweep run.
REQ-006 The block SHALL have port stop, input, 1 bit: abort the run.
REQ-007 The block SHALL have port pause, input, 1 bit: level input that freezes counting while high.
REQ-008 The block SHALL have port mode, input, 1 bit: 0 = sawtooth, 1 = triangle.
REQ-009 The block SHALL have port start_val, input, N bits: value loaded at the start of each sawtooth ramp and of the run.
REQ-010 The block SHALL have port n_sweeps, input, C bits: number of sweeps to run; 0 = run forever.
REQ-011 The block SHALL have ports max_tick and min_tick, inputs, 1 bit each: the counter's all-ones and zero flags.
REQ-012 The block SHALL have ports load, en and up, outputs, 1 bit each: the counter controls.
REQ-013 The block SHALL have port D, output, N bits: the counter's load value.
REQ-014 The block SHALL have ports busy and done, outputs, 1 bit each.
REQ-015 The block SHALL have port sweep_cnt, output, C bits: the number of sweeps completed.

Function
REQ-016 The FSM SHALL have exactly six states: IDLE, LOAD, UP, DOWN, PAUSE, DONE.
REQ-017 On a start edge, IDLE SHALL go to LOAD; in the same edge, start_val, mode and n_sweeps SHALL be latched and sweep_cnt cleared.
- start is ignored in all other states.
REQ-018 LOAD SHALL drive load=1, en=0, up=1 and D=latched start_val, then go to UP.
REQ-019 UP SHALL drive up=1 and en=~max_tick.
- On max_tick=1 in triangle mode, UP SHALL go to DOWN.
- On max_tick=1 in sawtooth mode, UP SHALL complete a sweep.
REQ-020 DOWN SHALL drive up=0 and en=~min_tick; on min_tick=1 it SHALL complete a sweep.
REQ-021 On sweep completion, sweep_cnt SHALL increment.
- If n_sweeps!=0 and the incremented count equals n_sweeps, the next state SHALL be DONE.
- Otherwise the next state SHALL be LOAD in sawtooth mode, or UP in triangle mode.
REQ-022 sweep_cnt SHALL saturate at all-ones when n_sweeps=0.
REQ-023 While pause=1 in UP or DOWN, the next state SHALL be PAUSE and the current direction SHALL be saved.
- PAUSE SHALL drive en=0 and load=0.
- PAUSE SHALL return to the saved state in the cycle after pause falls.
REQ-024 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-025 stop=1 SHALL force the next state to IDLE from any state.
- Priority: stop > pause > tick handling.
REQ-026 busy SHALL be 1 in LOAD, UP, DOWN and PAUSE, and 0 in IDLE and DONE.
REQ-027 Outputs SHALL be decoded from the state and ticks with no registered delay.
- load, en, up and done SHALL be 0 in IDLE.
REQ-028 The block SHALL never drive en=1 while the tick for the current direction is high.
- As a result, the counter never wraps and dwells exactly one cycle at each turnaround.
REQ-029 start_val = all-ones in triangle mode SHALL give LOAD -> UP with an immediate turn -> DOWN.
REQ-030 start_val = 0 in triangle mode SHALL sweep normally.

Reset
REQ-031 rst=1 at a clock edge SHALL force: state IDLE, sweep_cnt 0, latched registers 0, and all outputs 0 in the following cycle.
REQ-032 Reset SHALL override start and stop, including a reset applied mid-sweep.

Configuration
REQ-033 With macro SWEEP_CONTROLLER_PAUSE_EN defined, pause SHALL behave per REQ-023.
REQ-034 Without SWEEP_CONTROLLER_PAUSE_EN, the PAUSE state and saved-direction register SHALL be absent and pause SHALL be ignored.

Structure
REQ-035 State encodings (3-bit) and the MODE_SAW=0 and MODE_TRI=1 constants SHALL live in the shared package sweep_controller_pkg.
REQ-036 The block SHALL be a single module with no sub-modules; the FSM and the sweep counter SHALL be inline.

Verification
REQ-037 N=4, mode=0, start_val=12, n_sweeps=2, start: D=12 with load pulsed twice, ramps 12..15, done one cycle after the second max_tick, sweep_cnt=2.
REQ-038 N=4, mode=1, start_val=0, n_sweeps=1: Q runs 0..15..0 with no wrap, done once, busy for 33 cycles.
REQ-039 In triangle mode with n_sweeps=0, stop raised mid-DOWN: IDLE next cycle, en=0 and busy=0.
REQ-040 pause held 5 cycles in UP at Q=7: Q holds 7 for the duration, then resumes 8 upward.
- The same stimulus with SWEEP_CONTROLLER_PAUSE_EN undefined: counting continues through the pause.
REQ-041 rst asserted mid-UP: all outputs 0 next cycle, and start is ignored while rst=1.
REQ-042 start pulsed while busy: no reload, and sweep_cnt is unchanged.

Source files
------------

// File: rtl/sweep_controller_pkg.sv
// sweep_controller_pkg
//   Shared definitions for the sweep controller: the 3-bit FSM state
//   encoding and the sweep-mode constants.
package sweep_controller_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        UP    = 3'd2,
        DOWN  = 3'd3,
        PAUSE = 3'd4,
        DONE  = 3'd5
    } state_e;

    localparam logic MODE_SAW = 1'b0;
    localparam logic MODE_TRI = 1'b1;

endpackage

// File: rtl/sweep_controller.sv
// sweep_controller
//   Drives an external up/down counter through sawtooth or triangle sweeps.
//   A run is started by a one-cycle start pulse in IDLE; start_val, mode and
//   n_sweeps are captured on that edge. Sawtooth reloads start_val and ramps
//   up to all-ones; triangle ramps up to all-ones then down to zero. The
//   counter is never enabled while the tick for the current direction is
//   high, so it never wraps and dwells one cycle at every turnaround.
//
//   Optional feature: define SWEEP_CONTROLLER_PAUSE_EN to enable the pause
//   input (PAUSE state plus saved direction). Without it pause is ignored.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start, stop       run request (IDLE only) / abort to IDLE from anywhere
//   pause             level freeze of counting (feature-gated)
//   mode              0 sawtooth, 1 triangle
//   start_val [N]     ramp start value
//   n_sweeps  [C]     sweeps per run, 0 = forever
//   max_tick,min_tick counter all-ones / zero flags
//   load, en, up, D   counter controls and load value
//   busy, done        run active / one-cycle run-complete pulse
//   sweep_cnt [C]     sweeps completed in this run (saturating)
module sweep_controller
    import sweep_controller_pkg::*;
#(
    parameter int N = 8,
    parameter int C = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic         pause,
    input  logic         mode,
    input  logic [N-1:0] start_val,
    input  logic [C-1:0] n_sweeps,
    input  logic         max_tick,
    input  logic         min_tick,
    output logic         load,
    output logic         en,
    output logic         up,
    output logic [N-1:0] D,
    output logic         busy,
    output logic         done,
    output logic [C-1:0] sweep_cnt
);

    state_e         state_q, state_d;
    logic [N-1:0]   start_val_q, start_val_d;
    logic           mode_q, mode_d;
    logic [C-1:0]   n_sweeps_q, n_sweeps_d;
    logic [C-1:0]   sweep_cnt_q, sweep_cnt_d;
    logic [C-1:0]   cnt_inc;
    logic           sweep_end;

`ifdef SWEEP_CONTROLLER_PAUSE_EN
    logic           dir_up_q, dir_up_d;
`else
    logic           unused_pause;
    assign unused_pause = pause;
`endif

    // Saturating increment: only reachable at all-ones in free-run mode,
    // since a finite run ends when the count reaches n_sweeps.
    assign cnt_inc   = (&sweep_cnt_q) ? sweep_cnt_q : sweep_cnt_q + 1'b1;
    assign sweep_cnt = sweep_cnt_q;

    always_comb begin
        state_d     = state_q;
        start_val_d = start_val_q;
        mode_d      = mode_q;
        n_sweeps_d  = n_sweeps_q;
        sweep_cnt_d = sweep_cnt_q;
`ifdef SWEEP_CONTROLLER_PAUSE_EN
        dir_up_d    = dir_up_q;
`endif
        load      = 1'b0;
        en        = 1'b0;
        up        = 1'b0;
        D         = '0;
        busy      = 1'b0;
        done      = 1'b0;
        sweep_end = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = LOAD;
                    start_val_d = start_val;
                    mode_d      = mode;
                    n_sweeps_d  = n_sweeps;
                    sweep_cnt_d = '0;
                end
            end
            LOAD: begin
                load    = 1'b1;
                up      = 1'b1;
                D       = start_val_q;
                busy    = 1'b1;
                state_d = UP;
            end
            UP: begin
                up   = 1'b1;
                en   = ~max_tick;
                busy = 1'b1;
                if (max_tick) begin
                    if (mode_q == MODE_TRI) state_d = DOWN;
                    else                    sweep_end = 1'b1;
                end
            end
            DOWN: begin
                en   = ~min_tick;
                busy = 1'b1;
                if (min_tick) sweep_end = 1'b1;
            end
`ifdef SWEEP_CONTROLLER_PAUSE_EN
            PAUSE: begin
                // Direction output keeps the saved value; counter frozen.
                up   = dir_up_q;
                busy = 1'b1;
                if (!pause) state_d = dir_up_q ? UP : DOWN;
            end
`endif
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (sweep_end) begin
            sweep_cnt_d = cnt_inc;
            if ((n_sweeps_q != '0) && (cnt_inc == n_sweeps_q))
                state_d = DONE;
            else
                state_d = (mode_q == MODE_TRI) ? UP : LOAD;
        end

`ifdef SWEEP_CONTROLLER_PAUSE_EN
        // Pause outranks tick handling: the sweep is not counted and the
        // counter is held already in the cycle pause is first seen.
        if (pause && (state_q == UP || state_q == DOWN)) begin
            state_d     = PAUSE;
            dir_up_d    = (state_q == UP);
            sweep_cnt_d = sweep_cnt_q;
            en          = 1'b0;
        end
`endif

        // Stop outranks everything; nothing else in this cycle takes effect.
        if (stop) begin
            state_d     = IDLE;
            start_val_d = start_val_q;
            mode_d      = mode_q;
            n_sweeps_d  = n_sweeps_q;
            sweep_cnt_d = sweep_cnt_q;
`ifdef SWEEP_CONTROLLER_PAUSE_EN
            dir_up_d    = dir_up_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            start_val_q <= '0;
            mode_q      <= 1'b0;
            n_sweeps_q  <= '0;
            sweep_cnt_q <= '0;
`ifdef SWEEP_CONTROLLER_PAUSE_EN
            dir_up_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            start_val_q <= start_val_d;
            mode_q      <= mode_d;
            n_sweeps_q  <= n_sweeps_d;
            sweep_cnt_q <= sweep_cnt_d;
`ifdef SWEEP_CONTROLLER_PAUSE_EN
            dir_up_q    <= dir_up_d;
`endif
        end
    end

endmodule

// File: tb/tb_sweep_controller.sv
// tb_sweep_controller
//   Self-checking bench for sweep_controller with N=4, C=8. A behavioural
//   4-bit up/down counter closes the loop (Q, max_tick, min_tick). Full runs
//   come from a vector table; expected results are queued when a run is
//   started and popped when done is seen. Hand sequences cover stop, pause,
//   reset mid-run, start while busy and sweep_cnt saturation.
module tb_sweep_controller;

    localparam int N = 4;
    localparam int C = 8;

    logic         clk, rst, start, stop, pause, mode;
    logic [N-1:0] start_val;
    logic [C-1:0] n_sweeps;
    logic         max_tick, min_tick;
    logic         load, en, up, busy, done;
    logic [N-1:0] D;
    logic [C-1:0] sweep_cnt;

    sweep_controller #(.N(N), .C(C)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .mode(mode), .start_val(start_val), .n_sweeps(n_sweeps),
        .max_tick(max_tick), .min_tick(min_tick),
        .load(load), .en(en), .up(up), .D(D),
        .busy(busy), .done(done), .sweep_cnt(sweep_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External counter model
    logic [N-1:0] Q = '0;
    always @(posedge clk) begin
        if (load)    Q <= D;
        else if (en) Q <= up ? Q + 4'd1 : Q - 4'd1;
    end
    assign max_tick = (Q == 4'hF);
    assign min_tick = (Q == 4'h0);

    // Free-running observers, sampled mid-cycle
    int busy_cyc = 0, load_cnt = 0, done_cnt = 0, wrap_err = 0, d_err = 0;
    logic [N-1:0] cur_sv = '0;
    always @(negedge clk) begin
        if (busy) busy_cyc++;
        if (done) done_cnt++;
        if (load) begin
            load_cnt++;
            if (D != cur_sv) d_err++;
        end
        if (en && (up ? max_tick : min_tick)) wrap_err++;
    end

    int total = 0, bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic         mode;
        logic [N-1:0] sv;
        logic [C-1:0] ns;
        int           busy_exp;
        int           loads_exp;
    } vec_t;

    vec_t tbl[7];
    vec_t exp_q[$];

    task automatic wait_done(output bit ok, output int cnt);
        ok  = 1'b0;
        cnt = -1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done) begin
                ok  = 1'b1;
                cnt = int'(sweep_cnt);
                return;
            end
        end
    endtask

    task automatic pulse_start(input logic m, input logic [N-1:0] sv, input logic [C-1:0] ns);
        @(negedge clk);
        mode = m; start_val = sv; n_sweeps = ns; cur_sv = sv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scramble inputs after the start edge: the run must use latched copies.
        mode = ~m; start_val = ~sv; n_sweeps = ns + 8'd1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   b0, l0, d0, cnt;
        bit   ok;
        vec_t e;
        b0 = busy_cyc; l0 = load_cnt; d0 = done_cnt;
        exp_q.push_back(v);
        pulse_start(v.mode, v.sv, v.ns);
        wait_done(ok, cnt);
        repeat (2) @(negedge clk);
        e = exp_q.pop_front();
        chk($sformatf("v%0d_done_seen", idx), int'(ok), 1);
        chk($sformatf("v%0d_sweep_cnt", idx), cnt, int'(e.ns));
        chk($sformatf("v%0d_busy_cycles", idx), busy_cyc - b0, e.busy_exp);
        chk($sformatf("v%0d_loads", idx), load_cnt - l0, e.loads_exp);
        chk($sformatf("v%0d_done_pulses", idx), done_cnt - d0, 1);
        chk($sformatf("v%0d_idle_busy", idx), int'(busy), 0);
    endtask

    // Wait (bounded) for a negedge where cond_sel's condition holds
    task automatic wait_for(input int sel, input logic [N-1:0] qv, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            case (sel)
                0: ok = busy && !up && !load && (Q == qv);          // in DOWN at qv
                1: ok = up && en && (Q == qv);                      // in UP at qv
                2: ok = up && en && (sweep_cnt >= 8'd2);            // UP after 2 sweeps
                default: ok = 1'b0;
            endcase
            if (ok) return;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int cnt, l0;
        int qs[7];
        int exp_qs[7];

        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 1'b0;
        start_val = '0; n_sweeps = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", int'({load, en, up, done, busy, D, sweep_cnt}), 0);
        rst = 1'b0;

        // mode, start_val, n_sweeps, busy cycles, load pulses
        tbl[0] = '{1'b0, 4'd12, 8'd2, 10, 2};
        tbl[1] = '{1'b1, 4'd0,  8'd1, 33, 1};
        tbl[2] = '{1'b1, 4'd15, 8'd1, 18, 1};
        tbl[3] = '{1'b0, 4'd0,  8'd1, 17, 1};
        tbl[4] = '{1'b1, 4'd0,  8'd2, 65, 1};
        tbl[5] = '{1'b0, 4'd14, 8'd3,  9, 3};
        tbl[6] = '{1'b1, 4'd10, 8'd1, 23, 1};
        for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

        // Stop mid-DOWN in free-running triangle mode
        pulse_start(1'b1, 4'd0, 8'd0);
        wait_for(0, 4'd9, ok);
        chk("stop_reached_down", int'(ok), 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_busy", int'(busy), 0);
        chk("stop_en", int'(en), 0);
        @(negedge clk);
        chk("stop_stays_idle", int'(busy), 0);

        // Pause for 5 cycles in UP at Q=7
        pulse_start(1'b0, 4'd0, 8'd1);
        wait_for(1, 4'd7, ok);
        chk("pause_reached_q7", int'(ok), 1);
        pause = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            qs[k] = int'(Q);
        end
        pause = 1'b0;
        @(negedge clk); qs[5] = int'(Q);
        @(negedge clk); qs[6] = int'(Q);
`ifdef SWEEP_CONTROLLER_PAUSE_EN
        exp_qs = '{7, 7, 7, 7, 7, 7, 8};
`else
        exp_qs = '{8, 9, 10, 11, 12, 13, 14};
`endif
        for (int k = 0; k < 7; k++) chk($sformatf("pause_q%0d", k), qs[k], exp_qs[k]);
        wait_done(ok, cnt);
        chk("pause_run_cnt", cnt, 1);

        // Reset mid-UP with start held alongside reset
        pulse_start(1'b0, 4'd14, 8'd0);
        wait_for(2, 4'd0, ok);
        chk("rst_reached_up", int'(ok), 1);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("rst_outputs0", int'({load, en, up, done, busy, D, sweep_cnt}), 0);
        @(negedge clk);
        chk("rst_outputs1", int'({load, en, up, done, busy, D, sweep_cnt}), 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_then_idle", int'(busy), 0);

        // Start pulsed while busy: ignored
        l0 = load_cnt;
        pulse_start(1'b0, 4'd12, 8'd2);
        wait_for(1, 4'd13, ok);
        chk("busy_reached_q13", int'(ok), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_load", int'(load), 0);
        chk("busy_start_q", int'(Q), 14);
        chk("busy_start_cnt", int'(sweep_cnt), 0);
        wait_done(ok, cnt);
        repeat (2) @(negedge clk);
        chk("busy_start_final_cnt", cnt, 2);
        chk("busy_start_loads", load_cnt - l0, 2);

        // Free-run saturation: 2-cycle sawtooth sweeps past 255
        pulse_start(1'b0, 4'd15, 8'd0);
        repeat (700) @(negedge clk);
        chk("sat_cnt", int'(sweep_cnt), 255);
        chk("sat_busy", int'(busy), 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("sat_stop_busy", int'(busy), 0);

        chk("no_wrap_enable", wrap_err, 0);
        chk("load_value_D", d_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
